// File: rtl/mdnf_sweep_ctrl_if.sv
// Sweep controller bus: start/abort from the test master, x/z to the function under test, results out.
// Latency: none, wiring only.
// Backpressure: none; start is a level request, results hold until the next accepted sweep.
interface mdnf_sweep_ctrl_if #(
    parameter int N_IN = 4
);
    logic                 start;
    logic                 abort;
    logic                 z_in;
    logic [N_IN-1:0]      x_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2**N_IN-1:0]   tt_out;
    logic [N_IN:0]        err_cnt;
    logic [N_IN-1:0]      first_err_idx;
    logic                 first_err_vld;

    // Test/config master plus the function under test: drives requests and z, observes results.
    modport master (
        output start, abort, z_in,
        input  x_out, busy, done, pass, tt_out, err_cnt, first_err_idx, first_err_vld
    );

    // Sweep controller side.
    modport slave (
        input  start, abort, z_in,
        output x_out, busy, done, pass, tt_out, err_cnt, first_err_idx, first_err_vld
    );
endinterface

// File: rtl/mdnf_sweep_ctrl.sv
// Steps a combinational function through every input vector, captures z and compares to a golden table.
// Latency: start sampled at edge t -> done pulse in cycle t+1+2**N_IN*(SETTLE+1).
// Backpressure: start ignored while busy or in DONE (no queuing); abort cancels a sweep in progress.
module mdnf_sweep_ctrl #(
    parameter int                 N_IN   = 4,
    parameter int                 SETTLE = 1,
    parameter logic [2**N_IN-1:0] EXPECT = 16'h0AC5
) (
    input  logic               clk,
    input  logic               rst,
    mdnf_sweep_ctrl_if.slave   bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Settle counter only has to reach SETTLE-1.
    localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [N_IN-1:0] IDX_LAST = '1;
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

    logic [1:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic [N_IN-1:0]     r_idx;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [2**N_IN-1:0]  r_tt;
    logic [N_IN:0]       r_err_cnt;
    logic [N_IN-1:0]     r_first_idx;
    logic                r_first_vld;

    logic                w_mis;

    assign w_mis = (bus.z_in != EXPECT[r_idx]);

    assign bus.x_out         = r_idx;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.pass          = r_pass;
    assign bus.tt_out        = r_tt;
    assign bus.err_cnt       = r_err_cnt;
    assign bus.first_err_idx = r_first_idx;
    assign bus.first_err_vld = r_first_vld;

    // Sweep sequencer: IDLE -> (WAIT x SETTLE, SAMPLE) per vector -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_tt        <= '0;
            r_err_cnt   <= '0;
            r_first_idx <= '0;
            r_first_vld <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Results from the previous sweep stay visible until a new sweep is accepted.
                    if (bus.start) begin
                        r_state     <= S_WAIT;
                        r_idx       <= '0;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_tt        <= '0;
                        r_err_cnt   <= '0;
                        r_pass      <= 1'b0;
                        r_first_idx <= '0;
                        r_first_vld <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_pass  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_SAMPLE: begin
                    // Partial table and error count survive an abort for debug.
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_pass  <= 1'b0;
                    end else begin
                        r_tt[r_idx] <= bus.z_in;
                        if (w_mis) begin
                            r_err_cnt <= r_err_cnt + ERR_ONE;
                            if (!r_first_vld) begin
                                r_first_idx <= r_idx;
                                r_first_vld <= 1'b1;
                            end
                        end
                        if (r_idx == IDX_LAST) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_idx   <= '0;
                        end else begin
                            r_idx   <= r_idx + IDX_ONE;
                            r_cnt   <= '0;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    // err_cnt already includes the last sample here.
                    r_done  <= 1'b1;
                    r_pass  <= (r_err_cnt == '0);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdnf_sweep_ctrl.sv
// Bench for mdnf_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) share start/abort/rst.
// z_in comes from a table-driven function model that returns the inverted value until x_out
// has been stable SETTLE cycles, so an early sample shows up as a wrong table bit.
module tb_mdnf_sweep_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] pat;
    logic [15:0] gold;
    int          age1 = 0;
    int          age3 = 0;
    logic [3:0]  px1  = '0;
    logic [3:0]  px3  = '0;
    int          n_chk  = 0;
    int          n_fail = 0;

    typedef struct {
        logic [15:0] pat;
        logic [15:0] e_tt;
        int          e_err;
        int          e_first;
        bit          e_vld;
        bit          e_pass;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    mdnf_sweep_ctrl_if #(.N_IN(4)) bus1 ();
    mdnf_sweep_ctrl_if #(.N_IN(4)) bus3 ();

    mdnf_sweep_ctrl #(.N_IN(4), .SETTLE(1), .EXPECT(16'h0AC5)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mdnf_sweep_ctrl #(.N_IN(4), .SETTLE(3), .EXPECT(16'h0AC5)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    assign bus1.start = start;
    assign bus1.abort = abort;
    assign bus3.start = start;
    assign bus3.abort = abort;
    assign bus1.z_in  = (age1 >= 1) ? pat[bus1.x_out] : ~pat[bus1.x_out];
    assign bus3.z_in  = (age3 >= 3) ? pat[bus3.x_out] : ~pat[bus3.x_out];

    // Count how many cycles each x_out has been held (0 in the first cycle of a new value).
    always @(negedge clk) begin
        if (bus1.x_out == px1) age1 <= (age1 < 1000) ? age1 + 1 : age1;
        else                   age1 <= 0;
        px1 <= bus1.x_out;
        if (bus3.x_out == px3) age3 <= (age3 < 1000) ? age3 + 1 : age3;
        else                   age3 <= 0;
        px3 <= bus3.x_out;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Pulse start, then watch LIM cycles; k = cycles after the edge that sampled start.
    task automatic sweep(input int re_a, input int re_b, input int ab_k, input int rs_k,
                         output int l1, output int l3, output int p1, output int p3);
        l1 = -1; l3 = -1; p1 = 0; p3 = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 72; k++) begin
            @(negedge clk);
            start = (k == re_a) || (k == re_b);
            abort = (k == ab_k);
            rst   = (k == rs_k);
            if (k == 0) chk("busy_after_start", 64'(bus1.busy), 64'd1);
            if (bus1.done) begin p1++; if (l1 < 0) l1 = k; end
            if (bus3.done) begin p3++; if (l3 < 0) l3 = k; end
            if (ab_k >= 0 && k == ab_k + 1) begin
                chk("abort_busy1", 64'(bus1.busy), 64'd0);
                chk("abort_x1",    64'(bus1.x_out), 64'd0);
                chk("abort_busy3", 64'(bus3.busy), 64'd0);
                chk("abort_x3",    64'(bus3.x_out), 64'd0);
            end
            if (rs_k >= 0 && k == rs_k + 1) begin
                chk("rst_clear1", 64'({bus1.x_out, bus1.busy, bus1.done, bus1.pass, bus1.tt_out,
                                       bus1.err_cnt, bus1.first_err_idx, bus1.first_err_vld}), 64'd0);
                chk("rst_clear3", 64'({bus3.x_out, bus3.busy, bus3.done, bus3.pass, bus3.tt_out,
                                       bus3.err_cnt, bus3.first_err_idx, bus3.first_err_vld}), 64'd0);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic check_results(input string tag, input logic [15:0] e_tt, input int e_err,
                                 input int e_first, input bit e_vld, input bit e_pass);
        chk({tag, " tt1"},    64'(bus1.tt_out), 64'(e_tt));
        chk({tag, " err1"},   64'(bus1.err_cnt), 64'(e_err));
        chk({tag, " first1"}, 64'(bus1.first_err_idx), 64'(e_first));
        chk({tag, " vld1"},   64'(bus1.first_err_vld), 64'(e_vld));
        chk({tag, " pass1"},  64'(bus1.pass), 64'(e_pass));
        chk({tag, " busy1"},  64'(bus1.busy), 64'd0);
        chk({tag, " tt3"},    64'(bus3.tt_out), 64'(e_tt));
        chk({tag, " err3"},   64'(bus3.err_cnt), 64'(e_err));
        chk({tag, " first3"}, 64'(bus3.first_err_idx), 64'(e_first));
        chk({tag, " vld3"},   64'(bus3.first_err_vld), 64'(e_vld));
        chk({tag, " pass3"},  64'(bus3.pass), 64'(e_pass));
        chk({tag, " busy3"},  64'(bus3.busy), 64'd0);
    endtask

    task automatic check_timing(input string tag, input int l1, input int l3, input int p1, input int p3);
        chk({tag, " lat1"},   64'(l1), 64'd33);
        chk({tag, " lat3"},   64'(l3), 64'd65);
        chk({tag, " pulse1"}, 64'(p1), 64'd1);
        chk({tag, " pulse3"}, 64'(p3), 64'd1);
    endtask

    initial begin
        int l1, l3, p1, p3;
        int e_err, e_first;
        bit e_vld;
        int mins[6];

        // Golden function from its minterm list.
        mins = '{0, 2, 6, 7, 9, 11};
        gold = '0;
        foreach (mins[i]) gold[mins[i]] = 1'b1;

        tbl[0] = '{16'h0AC5, 16'h0AC5,  0,  0, 1'b0, 1'b1};
        tbl[1] = '{16'h0000, 16'h0000,  6,  0, 1'b1, 1'b0};
        tbl[2] = '{16'h08C5, 16'h08C5,  1,  9, 1'b1, 1'b0};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 10,  1, 1'b1, 1'b0};
        tbl[4] = '{16'hF53A, 16'hF53A, 16,  0, 1'b1, 1'b0};
        tbl[5] = '{16'h8AC5, 16'h8AC5,  1, 15, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; pat = gold;
        repeat (3) @(negedge clk);
        chk("reset1", 64'({bus1.x_out, bus1.busy, bus1.done, bus1.pass, bus1.tt_out,
                           bus1.err_cnt, bus1.first_err_idx, bus1.first_err_vld}), 64'd0);
        chk("reset3", 64'({bus3.x_out, bus3.busy, bus3.done, bus3.pass, bus3.tt_out,
                           bus3.err_cnt, bus3.first_err_idx, bus3.first_err_vld}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed truth tables.
        for (int t = 0; t < 6; t++) begin
            pat = tbl[t].pat;
            sweep(-1, -1, -1, -1, l1, l3, p1, p3);
            check_timing($sformatf("tbl%0d", t), l1, l3, p1, p3);
            check_results($sformatf("tbl%0d", t), tbl[t].e_tt, tbl[t].e_err,
                          tbl[t].e_first, tbl[t].e_vld, tbl[t].e_pass);
        end

        // Random function outputs against the reference comparison.
        for (int r = 0; r < 10; r++) begin
            pat = 16'($urandom);
            e_err = 0; e_first = 0; e_vld = 1'b0;
            for (int i = 0; i < 16; i++) begin
                if (pat[i] != gold[i]) begin
                    e_err++;
                    if (!e_vld) begin e_first = i; e_vld = 1'b1; end
                end
            end
            sweep(-1, -1, -1, -1, l1, l3, p1, p3);
            check_timing($sformatf("rnd%0d", r), l1, l3, p1, p3);
            check_results($sformatf("rnd%0d", r), pat, e_err, e_first, e_vld, e_err == 0);
        end

        // start re-pulsed mid-sweep and while dut1 is in DONE: ignored, nothing queued.
        pat = gold;
        sweep(10, 32, -1, -1, l1, l3, p1, p3);
        check_timing("restart", l1, l3, p1, p3);
        check_results("restart", gold, 0, 0, 1'b0, 1'b1);

        // abort while dut1 waits on vector 5 (dut3 on vector 2).
        sweep(-1, -1, 10, -1, l1, l3, p1, p3);
        chk("abort pulse1", 64'(p1), 64'd0);
        chk("abort pulse3", 64'(p3), 64'd0);
        chk("abort pass1",  64'(bus1.pass), 64'd0);
        chk("abort tt1",    64'(bus1.tt_out), 64'(gold & 16'h001F));
        chk("abort err1",   64'(bus1.err_cnt), 64'd0);
        chk("abort tt3",    64'(bus3.tt_out), 64'(gold & 16'h0003));

        // reset while dut1 waits on vector 10, then a clean sweep.
        sweep(-1, -1, -1, 20, l1, l3, p1, p3);
        chk("rst pulse1", 64'(p1), 64'd0);
        chk("rst pulse3", 64'(p3), 64'd0);
        sweep(-1, -1, -1, -1, l1, l3, p1, p3);
        check_timing("post_rst", l1, l3, p1, p3);
        check_results("post_rst", gold, 0, 0, 1'b0, 1'b1);

        // start held high: next sweep begins on the first IDLE cycle after done.
        @(negedge clk);
        start = 1'b1;
        l1 = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 33) chk("held busy_at_done", 64'(bus1.busy), 64'd0);
            if (k == 34) chk("held busy_restart", 64'(bus1.busy), 64'd1);
            if (bus1.done && l1 < 0) l1 = k;
        end
        chk("held lat1", 64'(l1), 64'd33);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("held abort busy1", 64'(bus1.busy), 64'd0);
        chk("held abort busy3", 64'(bus3.busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
